// File: rtl/modport_router.sv
// Byte-serial packet router: one source, three 16-deep output FIFOs selected by header address.
// Checks packet parity, back-pressures the source with busy, and flushes ports left unread.
module modport_router #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned SOFT_TMO   = 30
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [7:0] data_in,
    output logic       busy,
    output logic       error,
    input  logic       read_enb_0,
    input  logic       read_enb_1,
    input  logic       read_enb_2,
    output logic       vld_out_0,
    output logic       vld_out_1,
    output logic       vld_out_2,
    output logic [7:0] data_out_0,
    output logic [7:0] data_out_1,
    output logic [7:0] data_out_2
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned TmoW = $clog2(SOFT_TMO + 1);
    localparam logic [CntW-1:0] CntFull   = CntW'(FIFO_DEPTH);
    localparam logic [CntW-1:0] CntAlmost = CntW'(FIFO_DEPTH - 1);
    localparam logic [TmoW-1:0] TmoLast   = TmoW'(SOFT_TMO - 1);

    typedef enum logic [2:0] {StDecode, StWaitEmpty, StLoadData, StFull, StCheck} state_e;

    state_e     state_q, state_d;
    logic [1:0] addr_q, addr_d;
    logic [7:0] parity_q, parity_d;
    logic [7:0] recv_q, recv_d;
    logic       error_q, error_d;
    logic       drop_q, drop_d;

    logic [7:0]      mem_q [3][FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q [3];
    logic [PtrW-1:0] wr_ptr_d [3];
    logic [PtrW-1:0] rd_ptr_q [3];
    logic [PtrW-1:0] rd_ptr_d [3];
    logic [CntW-1:0] cnt_q [3];
    logic [CntW-1:0] cnt_d [3];
    logic [TmoW-1:0] tmo_q [3];
    logic [TmoW-1:0] tmo_d [3];
    logic [7:0]      dout_q [3];
    logic [7:0]      dout_d [3];

    logic [2:0] rd_req, empty, full, pop, push, flush;
    logic [1:0] hdr_addr;
    logic       abandon;

    assign rd_req   = {read_enb_2, read_enb_1, read_enb_0};
    assign hdr_addr = data_in[1:0];

    // FIFO status and idle-read timers; independent of the FSM so no combinational loop forms.
    always_comb begin
        for (int n = 0; n < 3; n++) begin
            empty[n] = (cnt_q[n] == '0);
            full[n]  = (cnt_q[n] == CntFull);
            pop[n]   = rd_req[n] & ~empty[n];
            flush[n] = ~empty[n] & ~rd_req[n] & (tmo_q[n] == TmoLast);
            if (empty[n] || rd_req[n] || flush[n]) begin
                tmo_d[n] = '0;
            end else begin
                tmo_d[n] = tmo_q[n] + TmoW'(1);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        parity_d = parity_q;
        recv_d   = recv_q;
        error_d  = error_q;
        drop_d   = drop_q;
        busy     = 1'b0;
        push     = '0;
        abandon  = flush[addr_q] && (state_q == StLoadData || state_q == StFull);
        case (state_q)
            StDecode: begin
                if (drop_q) begin
                    // Discard the rest of an addr-3 packet up to its parity byte.
                    if (!pkt_valid) drop_d = 1'b0;
                end else if (pkt_valid) begin
                    if (hdr_addr == 2'd3) begin
                        drop_d = 1'b1;
                    end else begin
                        addr_d = hdr_addr;
                        if (empty[hdr_addr]) begin
                            push[hdr_addr] = 1'b1;
                            parity_d       = data_in;
                            state_d        = StLoadData;
                        end else begin
                            state_d = StWaitEmpty;
                        end
                    end
                end
            end
            StWaitEmpty: begin
                busy = 1'b1;
                if (empty[addr_q]) begin
                    push[addr_q] = 1'b1;
                    parity_d     = data_in;
                    state_d      = StLoadData;
                end
            end
            StLoadData: begin
                if (full[addr_q]) begin
                    state_d = StFull;
                end else if (pkt_valid) begin
                    push[addr_q] = 1'b1;
                    parity_d     = parity_q ^ data_in;
                    // Enter FULL as the FIFO fills so the source holds its next byte.
                    if (cnt_q[addr_q] == CntAlmost && !pop[addr_q]) state_d = StFull;
                end else begin
                    push[addr_q] = 1'b1;
                    recv_d       = data_in;
                    state_d      = StCheck;
                end
            end
            StFull: begin
                busy = 1'b1;
                if (!full[addr_q]) state_d = StLoadData;
            end
            StCheck: begin
                busy    = 1'b1;
                error_d = (parity_q != recv_q);
                state_d = StDecode;
            end
            default: state_d = StDecode;
        endcase
        if (abandon) begin
            push    = '0;
            state_d = StDecode;
        end
    end

    always_comb begin
        for (int n = 0; n < 3; n++) begin
            wr_ptr_d[n] = wr_ptr_q[n];
            rd_ptr_d[n] = rd_ptr_q[n];
            cnt_d[n]    = cnt_q[n];
            dout_d[n]   = dout_q[n];
            if (flush[n]) begin
                wr_ptr_d[n] = '0;
                rd_ptr_d[n] = '0;
                cnt_d[n]    = '0;
            end else begin
                if (push[n]) wr_ptr_d[n] = wr_ptr_q[n] + PtrW'(1);
                if (pop[n]) begin
                    rd_ptr_d[n] = rd_ptr_q[n] + PtrW'(1);
                    dout_d[n]   = mem_q[n][rd_ptr_q[n]];
                end
                if (push[n] && !pop[n]) cnt_d[n] = cnt_q[n] + CntW'(1);
                if (pop[n] && !push[n]) cnt_d[n] = cnt_q[n] - CntW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int n = 0; n < 3; n++) begin
            if (push[n]) mem_q[n][wr_ptr_q[n]] <= data_in;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StDecode;
            addr_q   <= '0;
            parity_q <= '0;
            recv_q   <= '0;
            error_q  <= 1'b0;
            drop_q   <= 1'b0;
            for (int n = 0; n < 3; n++) begin
                wr_ptr_q[n] <= '0;
                rd_ptr_q[n] <= '0;
                cnt_q[n]    <= '0;
                tmo_q[n]    <= '0;
                dout_q[n]   <= '0;
            end
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            parity_q <= parity_d;
            recv_q   <= recv_d;
            error_q  <= error_d;
            drop_q   <= drop_d;
            for (int n = 0; n < 3; n++) begin
                wr_ptr_q[n] <= wr_ptr_d[n];
                rd_ptr_q[n] <= rd_ptr_d[n];
                cnt_q[n]    <= cnt_d[n];
                tmo_q[n]    <= tmo_d[n];
                dout_q[n]   <= dout_d[n];
            end
        end
    end

    assign error      = error_q;
    assign vld_out_0  = ~empty[0];
    assign vld_out_1  = ~empty[1];
    assign vld_out_2  = ~empty[2];
    assign data_out_0 = dout_q[0];
    assign data_out_1 = dout_q[1];
    assign data_out_2 = dout_q[2];

endmodule

// File: tb/tb_modport_router.sv
// Directed bench for modport_router: expected bytes queued per port at send time,
// a monitor pops and compares whenever a port is read.
module tb_modport_router;

    logic       clock, resetn, pkt_valid, busy, error;
    logic [7:0] data_in;
    logic       read_enb_0, read_enb_1, read_enb_2;
    logic       vld_out_0, vld_out_1, vld_out_2;
    logic [7:0] data_out_0, data_out_1, data_out_2;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp0[$];
    logic [7:0] exp1[$];
    logic [7:0] exp2[$];
    logic [7:0] pkt[$];
    logic [2:0] pend = '0;

    modport_router dut (
        .clock      (clock),
        .resetn     (resetn),
        .pkt_valid  (pkt_valid),
        .data_in    (data_in),
        .busy       (busy),
        .error      (error),
        .read_enb_0 (read_enb_0),
        .read_enb_1 (read_enb_1),
        .read_enb_2 (read_enb_2),
        .vld_out_0  (vld_out_0),
        .vld_out_1  (vld_out_1),
        .vld_out_2  (vld_out_2),
        .data_out_0 (data_out_0),
        .data_out_1 (data_out_1),
        .data_out_2 (data_out_2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cmp_pop(input int p, input logic [7:0] act);
        int sz;
        logic [7:0] e;
        case (p)
            0: sz = exp0.size();
            1: sz = exp1.size();
            default: sz = exp2.size();
        endcase
        if (sz == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pop_port%0d: got %0h, expected no data", p, act);
        end else begin
            case (p)
                0: e = exp0.pop_front();
                1: e = exp1.pop_front();
                default: e = exp2.pop_front();
            endcase
            check($sformatf("pop_port%0d", p), {24'h0, act}, {24'h0, e});
        end
    endtask

    // Monitor: compare the byte popped at the previous posedge, then note pops for the next one.
    always @(negedge clock) begin
        if (pend[0]) cmp_pop(0, data_out_0);
        if (pend[1]) cmp_pop(1, data_out_1);
        if (pend[2]) cmp_pop(2, data_out_2);
        pend[0] = resetn && read_enb_0 && vld_out_0;
        pend[1] = resetn && read_enb_1 && vld_out_1;
        pend[2] = resetn && read_enb_2 && vld_out_2;
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_byte(input logic v, input logic [7:0] d);
        int guard;
        pkt_valid = v;
        data_in   = d;
        guard     = 0;
        while (busy && guard < 200) begin
            wait_cycles(1);
            guard++;
        end
        if (busy) check("busy_timeout", 32'(busy), 32'h0);
        wait_cycles(1);
    endtask

    task automatic push_exp(input int p, input logic [7:0] b);
        case (p)
            0: exp0.push_back(b);
            1: exp1.push_back(b);
            2: exp2.push_back(b);
            default: ;
        endcase
    endtask

    task automatic send_pkt(input int p);
        for (int i = 0; i < pkt.size(); i++) begin
            push_exp(p, pkt[i]);
            send_byte(i != pkt.size() - 1, pkt[i]);
        end
    endtask

    task automatic set_rd(input int p, input logic v);
        case (p)
            0: read_enb_0 = v;
            1: read_enb_1 = v;
            default: read_enb_2 = v;
        endcase
    endtask

    task automatic drain(input int p, input int n);
        set_rd(p, 1'b1);
        wait_cycles(n);
        set_rd(p, 1'b0);
        wait_cycles(1);
    endtask

    initial begin
        int g;
        resetn = 1'b0; pkt_valid = 1'b0; data_in = '0;
        read_enb_0 = 1'b0; read_enb_1 = 1'b0; read_enb_2 = 1'b0;
        #12;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_error", 32'(error), 32'h0);
        check("rst_vld", {29'h0, vld_out_2, vld_out_1, vld_out_0}, 32'h0);
        @(posedge clock);
        #2 resetn = 1'b1;
        wait_cycles(1);

        // Good packet to port 1
        pkt = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        send_pkt(1);
        wait_cycles(1);
        check("good_error", 32'(error), 32'h0);
        check("good_vld1", 32'(vld_out_1), 32'h1);
        drain(1, 5);
        check("good_drained", 32'(vld_out_1), 32'h0);

        // Bad parity: error rises one clock after the parity byte
        pkt = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'hFF};
        send_pkt(1);
        check("bad_err_not_yet", 32'(error), 32'h0);
        wait_cycles(1);
        check("bad_error", 32'(error), 32'h1);
        drain(1, 5);

        // Next good packet clears error
        pkt = '{8'h04, 8'hAA, 8'hAE};
        send_pkt(0);
        wait_cycles(1);
        check("clear_error", 32'(error), 32'h0);
        drain(0, 3);

        // Bad packet to port 2 left unread, then reset in the middle of another packet
        pkt = '{8'h06, 8'h5A, 8'h00};
        send_pkt(2);
        wait_cycles(1);
        check("bad2_error", 32'(error), 32'h1);
        send_byte(1'b1, 8'h0D);
        send_byte(1'b1, 8'h11);
        resetn = 1'b0;
        pkt_valid = 1'b0;
        #2;
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_error", 32'(error), 32'h0);
        check("mid_rst_vld", {29'h0, vld_out_2, vld_out_1, vld_out_0}, 32'h0);
        check("mid_rst_dout0", {24'h0, data_out_0}, 32'h0);
        check("mid_rst_dout1", {24'h0, data_out_1}, 32'h0);
        exp0.delete(); exp1.delete(); exp2.delete();
        @(posedge clock);
        #1 resetn = 1'b1;
        wait_cycles(1);

        // len=20 to port 0 with no reads: FIFO fills after 16 writes
        send_byte(1'b1, 8'h50);
        exp0.push_back(8'h50);
        for (int i = 1; i <= 15; i++) begin
            send_byte(1'b1, 8'(i));
            exp0.push_back(8'(i));
        end
        check("full_busy", 32'(busy), 32'h1);
        check("full_vld0", 32'(vld_out_0), 32'h1);
        pkt_valid = 1'b1;
        data_in = 8'd16;
        read_enb_0 = 1'b1;
        g = 0;
        while (busy && g < 10) begin
            wait_cycles(1);
            g++;
        end
        check("full_busy_drop", 32'(busy), 32'h0);
        for (int i = 16; i <= 20; i++) begin
            exp0.push_back(8'(i));
            send_byte(1'b1, 8'(i));
        end
        exp0.push_back(8'h44);
        send_byte(1'b0, 8'h44);
        wait_cycles(1);
        check("long_error", 32'(error), 32'h0);
        g = 0;
        while (vld_out_0 && g < 40) begin
            wait_cycles(1);
            g++;
        end
        read_enb_0 = 1'b0;
        wait_cycles(1);
        check("long_all_read", 32'(exp0.size()), 32'h0);

        // Port 2 left unread: flushed on the 30th idle clock after the header lands
        pkt = '{8'h06, 8'h5A, 8'h5C};
        send_pkt(2);
        wait_cycles(27);
        check("tmo_before", 32'(vld_out_2), 32'h1);
        wait_cycles(1);
        check("tmo_flushed", 32'(vld_out_2), 32'h0);
        exp2.delete();

        // addr 3: whole packet ignored, including a payload byte that looks like a header
        pkt = '{8'h07, 8'h02, 8'h05};
        send_pkt(3);
        check("addr3_busy", 32'(busy), 32'h0);
        wait_cycles(1);
        check("addr3_vld", {29'h0, vld_out_2, vld_out_1, vld_out_0}, 32'h0);

        // Router recovers; then reading an empty FIFO holds data_out
        pkt = '{8'h05, 8'h77, 8'h72};
        send_pkt(1);
        wait_cycles(1);
        check("recover_error", 32'(error), 32'h0);
        drain(1, 3);
        check("recover_all_read", 32'(exp1.size()), 32'h0);
        drain(1, 2);
        check("empty_read_hold", {24'h0, data_out_1}, 32'h72);
        check("empty_read_vld", 32'(vld_out_1), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
